stage_memory: RTL and testbench

// Pipeline stage directly downstream of the execute stage, and upstream of write-back.
// ALU ops pass through in one cycle. Loads and stores drive a req/ack data-memory port:
// - Byte enables and store-lane alignment are generated here.
// - Load data is sign/zero extended here.
// - Upstream is stalled until the memory acknowledges, or until a timeout aborts the access.

---
 rtl/stage_memory_if.sv | 20 ++
 rtl/stage_memory.sv | 185 ++++++++++++++++++
 tb/tb_stage_memory.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_memory_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and data memory (slave).
interface stage_memory_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/stage_memory.sv
// Memory pipeline stage: ALU results pass in one cycle, loads/stores run a req/ack
// transaction with lane alignment, load extension, misalignment abort and ack timeout.
module stage_memory #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 execute_valid,
  input  logic [31:0]          execute_alu_result,
  input  logic [4:0]           execute_rd,
  input  logic                 execute_wr_enable,
  input  logic                 execute_mem_to_reg,
  input  logic                 execute_mem_write,
  input  logic [2:0]           execute_funct3,
  input  logic [31:0]          execute_store_data,
  output logic                 mem_stall,
  stage_memory_if.master       dmem,
  output logic                 memory_valid,
  output logic [4:0]           memory_rd,
  output logic                 memory_wr_enable,
  output logic [31:0]          memory_result,
  output logic                 memory_misaligned,
  output logic                 memory_bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_n;
  logic [31:0] cnt;
  logic        is_mem_p0, misaligned_p0;
  logic        start_req, alu_pass, misalign, ack_done, timeout;
  logic [4:0]  rd_p1;
  logic        wr_en_p1, load_p1;
  logic [2:0]  funct3_p1;
  logic [1:0]  off_p1;

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'b0, sh[7:0]};
      3'b101:  load_extend = {16'b0, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  assign is_mem_p0 = execute_mem_to_reg | execute_mem_write;

  always_comb begin
    case (execute_funct3[1:0])
      2'b00:   misaligned_p0 = 1'b0;
      2'b01:   misaligned_p0 = execute_alu_result[0];
      default: misaligned_p0 = |execute_alu_result[1:0];
    endcase
  end

  assign mem_stall     = (state == S_WAIT);
  assign dmem.dmem_req = (state == S_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // ACK_TIMEOUT of 0 disables the abort entirely; ack beats timeout on the same edge
  always_comb begin
    state_n   = state;
    start_req = 1'b0;
    alu_pass  = 1'b0;
    misalign  = 1'b0;
    ack_done  = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (execute_valid) begin
          if (!is_mem_p0) begin
            alu_pass = 1'b1;
          end else if (misaligned_p0) begin
            misalign = 1'b1;
          end else begin
            start_req = 1'b1;
            state_n   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem.dmem_ack) begin
          ack_done = 1'b1;
          state_n  = S_IDLE;
        end else if (ACK_TIMEOUT != 0 && cnt == ACK_TIMEOUT - 1) begin
          timeout = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (start_req)        cnt <= '0;
    else if (state == S_WAIT)  cnt <= cnt + 1'b1;
  end

  // p0 -> p1: latch the bus request and the fields needed when the access completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
    end else if (start_req) begin
      dmem.dmem_we    <= execute_mem_write;
      dmem.dmem_addr  <= {execute_alu_result[31:2], 2'b00};
      dmem.dmem_be    <= lane_be(execute_funct3, execute_alu_result[1:0]);
      dmem.dmem_wdata <= lane_wdata(execute_funct3, execute_store_data);
    end
  end

  always_ff @(posedge clk) begin
    if (start_req) begin
      rd_p1     <= execute_rd;
      wr_en_p1  <= execute_wr_enable;
      load_p1   <= ~execute_mem_write;
      funct3_p1 <= execute_funct3;
      off_p1    <= execute_alu_result[1:0];
    end
  end

  // p1 -> p2: retire into the write-back registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memory_valid      <= 1'b0;
      memory_rd         <= '0;
      memory_wr_enable  <= 1'b0;
      memory_result     <= '0;
      memory_misaligned <= 1'b0;
      memory_bus_err    <= 1'b0;
    end else begin
      memory_valid      <= alu_pass | misalign | ack_done | timeout;
      memory_misaligned <= misalign;
      memory_bus_err    <= timeout;
      if (alu_pass) begin
        memory_rd        <= execute_rd;
        memory_wr_enable <= execute_wr_enable;
        memory_result    <= execute_alu_result;
      end else if (misalign) begin
        memory_rd        <= execute_rd;
        memory_wr_enable <= 1'b0;
        memory_result    <= execute_alu_result;
      end else if (ack_done) begin
        memory_rd        <= rd_p1;
        memory_wr_enable <= load_p1 & wr_en_p1;
        if (load_p1) memory_result <= load_extend(funct3_p1, off_p1, dmem.dmem_rdata);
      end else if (timeout) begin
        memory_rd        <= rd_p1;
        memory_wr_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: table of single-instruction vectors plus
// hand-written sequences for late ack, async reset during a wait, and timeout.
module tb_stage_memory;

  logic        clk;
  logic        rst_n;
  logic        execute_valid;
  logic [31:0] execute_alu_result;
  logic [4:0]  execute_rd;
  logic        execute_wr_enable;
  logic        execute_mem_to_reg;
  logic        execute_mem_write;
  logic [2:0]  execute_funct3;
  logic [31:0] execute_store_data;
  logic        mem_stall;
  logic        memory_valid;
  logic [4:0]  memory_rd;
  logic        memory_wr_enable;
  logic [31:0] memory_result;
  logic        memory_misaligned;
  logic        memory_bus_err;

  stage_memory_if dmem ();

  stage_memory #(.ACK_TIMEOUT(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .execute_valid      (execute_valid),
    .execute_alu_result (execute_alu_result),
    .execute_rd         (execute_rd),
    .execute_wr_enable  (execute_wr_enable),
    .execute_mem_to_reg (execute_mem_to_reg),
    .execute_mem_write  (execute_mem_write),
    .execute_funct3     (execute_funct3),
    .execute_store_data (execute_store_data),
    .mem_stall          (mem_stall),
    .dmem               (dmem),
    .memory_valid       (memory_valid),
    .memory_rd          (memory_rd),
    .memory_wr_enable   (memory_wr_enable),
    .memory_result      (memory_result),
    .memory_misaligned  (memory_misaligned),
    .memory_bus_err     (memory_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        wr;
    logic        m2r;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] sdata;
    int          delay;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        exp_wr;
    logic        chk_res;
    logic [31:0] exp_res;
    logic        exp_mis;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic drive(input logic [31:0] alu, input logic [4:0] rd, input logic wr,
                       input logic m2r, input logic mw, input logic [2:0] f3,
                       input logic [31:0] sdata);
    execute_valid      = 1'b1;
    execute_alu_result = alu;
    execute_rd         = rd;
    execute_wr_enable  = wr;
    execute_mem_to_reg = m2r;
    execute_mem_write  = mw;
    execute_funct3     = f3;
    execute_store_data = sdata;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    drive(v.alu, v.rd, v.wr, v.m2r, v.mw, v.f3, v.sdata);
    dmem.dmem_ack = 1'b0;
    chk($sformatf("v%0d_stall_idle", i), 32'(mem_stall), 32'd0);
    @(negedge clk);
    execute_valid = 1'b0;
    if (v.exp_req) begin
      chk($sformatf("v%0d_req", i), 32'(dmem.dmem_req), 32'd1);
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'd1);
      chk($sformatf("v%0d_addr", i), dmem.dmem_addr, v.exp_addr);
      chk($sformatf("v%0d_be", i), 32'(dmem.dmem_be), 32'(v.exp_be));
      chk($sformatf("v%0d_wdata", i), dmem.dmem_wdata, v.exp_wdata);
      chk($sformatf("v%0d_we", i), 32'(dmem.dmem_we), 32'(v.exp_we));
      chk($sformatf("v%0d_valid_wait", i), 32'(memory_valid), 32'd0);
      repeat (v.delay) @(negedge clk);
      dmem.dmem_ack   = 1'b1;
      dmem.dmem_rdata = v.rdata;
      @(negedge clk);
      dmem.dmem_ack   = 1'b0;
    end else begin
      chk($sformatf("v%0d_noreq", i), 32'(dmem.dmem_req), 32'd0);
    end
    chk($sformatf("v%0d_valid", i), 32'(memory_valid), 32'd1);
    chk($sformatf("v%0d_rd", i), 32'(memory_rd), 32'(v.rd));
    chk($sformatf("v%0d_wr_en", i), 32'(memory_wr_enable), 32'(v.exp_wr));
    chk($sformatf("v%0d_mis", i), 32'(memory_misaligned), 32'(v.exp_mis));
    chk($sformatf("v%0d_bus_err", i), 32'(memory_bus_err), 32'd0);
    if (v.chk_res) chk($sformatf("v%0d_result", i), memory_result, v.exp_res);
    @(negedge clk);
    chk($sformatf("v%0d_valid_drop", i), 32'(memory_valid), 32'd0);
    chk($sformatf("v%0d_mis_pulse", i), 32'(memory_misaligned), 32'd0);
  endtask

  initial begin
    int stall_cycles;
    //          alu           rd  wr m2r mw f3      sdata         dly rdata         req addr         be       wdata         we wr chk res           mis
    vecs[0]  = '{32'h00000007, 3, 1, 0, 0, 3'b000, 32'h0,        0, 32'h0,        0, 32'h0,       4'b0000, 32'h0,        0, 1, 1, 32'h00000007, 0};
    vecs[1]  = '{32'h00000103, 4, 1, 1, 0, 3'b000, 32'h0,        0, 32'h80FF0000, 1, 32'h100,     4'b1000, 32'h0,        0, 1, 1, 32'hFFFFFF80, 0};
    vecs[2]  = '{32'h00000103, 4, 1, 1, 0, 3'b100, 32'h0,        0, 32'h80FF0000, 1, 32'h100,     4'b1000, 32'h0,        0, 1, 1, 32'h00000080, 0};
    vecs[3]  = '{32'h00000102, 9, 1, 0, 1, 3'b001, 32'h1234ABCD, 0, 32'h0,        1, 32'h100,     4'b1100, 32'hABCDABCD, 1, 0, 0, 32'h0,        0};
    vecs[4]  = '{32'h00000102, 7, 1, 1, 0, 3'b001, 32'h0,        2, 32'h80011234, 1, 32'h100,     4'b1100, 32'h0,        0, 1, 1, 32'hFFFF8001, 0};
    vecs[5]  = '{32'h00000100, 8, 1, 1, 0, 3'b101, 32'h0,        0, 32'h1234F00D, 1, 32'h100,     4'b0011, 32'h0,        0, 1, 1, 32'h0000F00D, 0};
    vecs[6]  = '{32'h00000104, 10, 0, 1, 0, 3'b010, 32'h0,       2, 32'hDEADBEEF, 1, 32'h104,     4'b1111, 32'h0,        0, 0, 1, 32'hDEADBEEF, 0};
    vecs[7]  = '{32'h00000101, 11, 0, 0, 1, 3'b000, 32'h00000055, 0, 32'h0,       1, 32'h100,     4'b0010, 32'h55555555, 1, 0, 0, 32'h0,        0};
    vecs[8]  = '{32'h00000101, 12, 1, 1, 0, 3'b010, 32'h0,       0, 32'h0,        0, 32'h0,       4'b0000, 32'h0,        0, 0, 0, 32'h0,        1};
    vecs[9]  = '{32'h00000103, 13, 1, 1, 0, 3'b001, 32'h0,       0, 32'h0,        0, 32'h0,       4'b0000, 32'h0,        0, 0, 0, 32'h0,        1};
    vecs[10] = '{32'h00000108, 14, 0, 0, 1, 3'b011, 32'hCAFEF00D, 0, 32'h0,       1, 32'h108,     4'b1111, 32'hCAFEF00D, 1, 0, 0, 32'h0,        0};
    vecs[11] = '{32'h00000101, 16, 1, 1, 0, 3'b000, 32'h0,       0, 32'h00007F00, 1, 32'h100,     4'b0010, 32'h0,        0, 1, 1, 32'h0000007F, 0};
    vecs[12] = '{32'hFFFFFFFE, 31, 0, 0, 0, 3'b000, 32'h0,       0, 32'h0,        0, 32'h0,       4'b0000, 32'h0,        0, 0, 1, 32'hFFFFFFFE, 0};
    vecs[13] = '{32'h0000010A, 17, 0, 0, 1, 3'b010, 32'h11111111, 0, 32'h0,       0, 32'h0,       4'b0000, 32'h0,        0, 0, 0, 32'h0,        1};

    rst_n = 1'b1;
    execute_valid = 1'b0; execute_alu_result = '0; execute_rd = '0; execute_wr_enable = 1'b0;
    execute_mem_to_reg = 1'b0; execute_mem_write = 1'b0; execute_funct3 = '0; execute_store_data = '0;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(memory_valid), 32'd0);
    chk("rst_rd", 32'(memory_rd), 32'd0);
    chk("rst_wr_en", 32'(memory_wr_enable), 32'd0);
    chk("rst_result", memory_result, 32'd0);
    chk("rst_mis", 32'(memory_misaligned), 32'd0);
    chk("rst_bus_err", 32'(memory_bus_err), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_req", 32'(dmem.dmem_req), 32'd0);
    chk("rst_addr", dmem.dmem_addr, 32'd0);
    chk("rst_be", 32'(dmem.dmem_be), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Late ack: load stalls four cycles, the held ADD retires right after it
    @(negedge clk);
    drive(32'h200, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0);
    chk("late_stall_idle", 32'(mem_stall), 32'd0);
    stall_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drive(32'h7, 5'd6, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0);
      if (mem_stall) stall_cycles++;
      dmem.dmem_ack   = (k == 3);
      dmem.dmem_rdata = 32'h11223344;
    end
    @(negedge clk);
    dmem.dmem_ack = 1'b0;
    chk("late_stall_cycles", 32'(stall_cycles), 32'd4);
    chk("late_stall_end", 32'(mem_stall), 32'd0);
    chk("late_ld_valid", 32'(memory_valid), 32'd1);
    chk("late_ld_result", memory_result, 32'h11223344);
    chk("late_ld_rd", 32'(memory_rd), 32'd5);
    chk("late_ack_wins", 32'(memory_bus_err), 32'd0);
    @(negedge clk);
    execute_valid = 1'b0;
    chk("late_add_valid", 32'(memory_valid), 32'd1);
    chk("late_add_result", memory_result, 32'h7);
    chk("late_add_rd", 32'(memory_rd), 32'd6);

    // Async reset in the middle of a wait
    @(negedge clk);
    drive(32'h300, 5'd1, 1'b0, 1'b0, 1'b1, 3'b010, 32'hA5A5A5A5);
    @(negedge clk);
    execute_valid = 1'b0;
    chk("arst_req_before", 32'(dmem.dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(dmem.dmem_req), 32'd0);
    chk("arst_stall", 32'(mem_stall), 32'd0);
    chk("arst_addr", dmem.dmem_addr, 32'd0);
    chk("arst_wdata", dmem.dmem_wdata, 32'd0);
    chk("arst_result", memory_result, 32'd0);
    chk("arst_valid", 32'(memory_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h9, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0);
    @(negedge clk);
    execute_valid = 1'b0;
    chk("arst_alu_valid", 32'(memory_valid), 32'd1);
    chk("arst_alu_result", memory_result, 32'h9);
    chk("arst_alu_rd", 32'(memory_rd), 32'd2);

    // Timeout: no ack for four wait cycles
    @(negedge clk);
    drive(32'h400, 5'd15, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      execute_valid = 1'b0;
      chk($sformatf("to_stall_%0d", k), 32'(mem_stall), 32'd1);
      chk($sformatf("to_no_err_%0d", k), 32'(memory_bus_err), 32'd0);
    end
    @(negedge clk);
    chk("to_bus_err", 32'(memory_bus_err), 32'd1);
    chk("to_valid", 32'(memory_valid), 32'd1);
    chk("to_wr_en", 32'(memory_wr_enable), 32'd0);
    chk("to_rd", 32'(memory_rd), 32'd15);
    chk("to_stall_end", 32'(mem_stall), 32'd0);
    chk("to_req_end", 32'(dmem.dmem_req), 32'd0);
    @(negedge clk);
    chk("to_err_pulse", 32'(memory_bus_err), 32'd0);
    chk("to_valid_drop", 32'(memory_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
